otter_lsu: RTL and testbench
============================

# otter_lsu

Load/store unit for the OTTER RV32I core. It sits between the execute stage and the data port (port 2) of the OTTER memory, and it is the initiator on that port. The unit accepts one load or store request at a time and checks alignment and funct3 legality. It then sequences the synchronous-read or single-cycle-write protocol of the memory port and returns a registered, sized, sign-extended result with a one-cycle response strobe.

## Interface
- MMIO_BASE, 32'h00010000, first address of the memory-mapped IO range; only used to drive RSP_IO.
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- REQ_VALID  in  1  request strobe; sampled only when REQ_READY=1.
- REQ_READY  out  1  high only in IDLE.
- REQ_WE  in  1  1 = store, 0 = load.
- REQ_FUNCT3  in  3  RV32I funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- REQ_ADDR  in  32  byte address.
- REQ_WDATA  in  32  store data; value is in the low bits and is not lane-shifted.
- RSP_VALID  out  1  one-cycle completion pulse.
- RSP_RDATA  out  32  load result; valid while RSP_VALID=1, held until the next response.
- RSP_ERR  out  1  qualifies RSP_VALID: misaligned access or illegal funct3.
- RSP_IO  out  1  qualifies RSP_VALID: latched address >= MMIO_BASE.
- LSU_MEM_RDEN2  out  1  to memory read enable, port 2.
- LSU_MEM_WE2  out  1  to memory write enable, port 2.
- LSU_MEM_ADDR2  out  32  to memory byte address, port 2.
- LSU_MEM_DIN2  out  32  to memory write data, port 2.
- LSU_MEM_SIZE  out  2  to memory size: 0 byte, 1 half, 2 word.
- LSU_MEM_SIGN  out  1  to memory sign: 1 unsigned, 0 signed.
- MEM_DOUT2  in  32  from memory: sized, sign-extended read data.

## Operation
- States: IDLE, RD, RDW, WR, RESP. All outputs are registered or decoded from state alone; there is no combinational path from REQ_* to any output.
- IDLE, on REQ_VALID: latch addr, wdata, funct3 and we into ADDR2, DIN2, SIZE=funct3[1:0], SIGN=funct3[2]. Compute legality:
  - loads: funct3 in {000,001,010,100,101}.
  - stores: funct3 in {000,001,010}.
  - half accesses need addr[0]=0; word accesses need addr[1:0]=00. The memory accepts offset-1 halves, but the LSU flags them as errors per RV32I natural alignment.
- Next state from IDLE:
  - illegal request -> RESP with RSP_ERR=1. No memory strobe is issued and RSP_RDATA is set to 0.
  - legal load -> RD.
  - legal store -> WR.
- RD: RDEN2=1 for exactly one cycle -> RDW.
- RDW: RDEN2=0. ADDR2, SIZE and SIGN are held, because the memory sizes the data combinationally from the live address and size. Register MEM_DOUT2 into RSP_RDATA at the end of RDW -> RESP.
- WR: WE2=1 for exactly one cycle -> RESP. RSP_RDATA is set to 0.
- RESP: RSP_VALID=1 for one cycle; RSP_ERR and RSP_IO are valid -> IDLE.
- LSU_MEM_ADDR2, SIZE, SIGN and DIN2 hold their latched values from acceptance until the next acceptance.
- RDEN2 and WE2 are never asserted together.
- IO accesses follow the same sequence. The memory returns its IO buffer and routes WE2 to IO_WR; the LSU does not treat them specially beyond RSP_IO.

## Timing
- Reset (asynchronous, immediate):
  - state becomes IDLE; REQ_READY=1.
  - RSP_VALID, RSP_ERR, RSP_IO, RDEN2 and WE2 go to 0.
  - RSP_RDATA, ADDR2 and DIN2 go to 0; SIZE and SIGN go to 0.
- Load latency: accepted at edge 0; RD in cycle 1; RDW in cycle 2; RSP_VALID in cycle 3.
- Store latency: WR in cycle 1; RSP_VALID in cycle 2.
- Error latency: RSP_VALID in cycle 1.
- Throughput: the next request is accepted earliest in the cycle after RESP, i.e. one load per 4 cycles and one store per 3 cycles.
- REQ_VALID outside IDLE is ignored and not queued.
- Reset in the middle of WR deasserts WE2 asynchronously. The memory write happens only if a clock edge occurred with WE2=1 before reset asserted.
- Reset in the middle of RD or RDW drops the load, and RSP_VALID is never issued for it.
- Reset released with REQ_VALID already high: the request is accepted at the first edge after deassertion.

## Test plan
- Word 0x100 = 0x80FF1234; load funct3=000, addr 0x103 -> RSP_VALID in cycle 3, RSP_RDATA=0xFFFFFF80, RDEN2 high only in cycle 1, ADDR2 held 0x103 in cycles 1-2.
- Same word; funct3=100 at 0x103 -> 0x00000080; funct3=001 at 0x102 -> 0xFFFF80FF; funct3=101 at 0x100 -> 0x00001234; funct3=010 at 0x100 -> 0x80FF1234.
- Store funct3=000, addr 0x101, wdata 0xAB, then word load at 0x100 -> WE2 high for exactly one cycle, store RSP_VALID in cycle 2, load returns 0x80FFAB34.
- Misaligned and illegal requests: store funct3=010 at 0x102; load funct3=001 at 0x101; load funct3=011 -> each gives RSP_ERR=1 in cycle 1, RSP_RDATA=0, no RDEN2/WE2 pulse, and memory is unchanged.
- IO: IO_IN=0x12345678; word load at 0x11000000 -> RSP_IO=1, RSP_RDATA=0x12345678. Word store at 0x11000000 -> WE2 pulses once, so the memory's IO_WR pulses once.
- Assert RST during WR and during RDW -> outputs take their reset values immediately, no RSP_VALID follows, and the next request after release completes normally.

Source files
------------

// File: rtl/otter_lsu_if.sv
// Request/response bus between execute stage and LSU, and LSU-to-memory data port.
// Latency: none, these are plain wire bundles.
// Backpressure: REQ_READY gates acceptance; the memory port has no backpressure.
interface otter_lsu_if;
   logic        REQ_VALID;
   logic        REQ_READY;
   logic        REQ_WE;
   logic [2:0]  REQ_FUNCT3;
   logic [31:0] REQ_ADDR;
   logic [31:0] REQ_WDATA;
   logic        RSP_VALID;
   logic [31:0] RSP_RDATA;
   logic        RSP_ERR;
   logic        RSP_IO;

   modport master (output REQ_VALID, REQ_WE, REQ_FUNCT3, REQ_ADDR, REQ_WDATA,
                   input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR, RSP_IO);
   modport slave  (input  REQ_VALID, REQ_WE, REQ_FUNCT3, REQ_ADDR, REQ_WDATA,
                   output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR, RSP_IO);
endinterface

interface otter_mem_if;
   logic        LSU_MEM_RDEN2;
   logic        LSU_MEM_WE2;
   logic [31:0] LSU_MEM_ADDR2;
   logic [31:0] LSU_MEM_DIN2;
   logic [1:0]  LSU_MEM_SIZE;
   logic        LSU_MEM_SIGN;
   logic [31:0] MEM_DOUT2;

   modport master (output LSU_MEM_RDEN2, LSU_MEM_WE2, LSU_MEM_ADDR2, LSU_MEM_DIN2,
                          LSU_MEM_SIZE, LSU_MEM_SIGN,
                   input  MEM_DOUT2);
   modport slave  (input  LSU_MEM_RDEN2, LSU_MEM_WE2, LSU_MEM_ADDR2, LSU_MEM_DIN2,
                          LSU_MEM_SIZE, LSU_MEM_SIGN,
                   output MEM_DOUT2);
endinterface

// File: rtl/otter_lsu.sv
// Load/store unit: one request at a time, legality check, drives memory port 2.
// Latency: load 3 cycles, store 2 cycles, illegal request 1 cycle to RSP_VALID.
// Backpressure: REQ_READY only in IDLE; requests arriving while busy are dropped.
module otter_lsu #(
   parameter logic [31:0] MMIO_BASE = 32'h00010000
) (
   input  logic         CLK,
   input  logic         RST,
   otter_lsu_if.slave   req,
   otter_mem_if.master  mem
);

   typedef enum logic [2:0] {S_IDLE, S_RD, S_RDW, S_WR, S_RESP} state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q,  addr_d;
   logic [31:0] din_q,   din_d;
   logic [31:0] rdata_q, rdata_d;
   logic [1:0]  size_q,  size_d;
   logic        sign_q,  sign_d;
   logic        err_q,   err_d;
   logic        io_q,    io_d;

   logic        accept;
   logic        f3_legal;
   logic        aligned;
   logic        req_ok;

   // Decode funct3 legality and natural alignment of the incoming request
   always_comb begin
      accept = (state_q == S_IDLE) && req.REQ_VALID;
      case (req.REQ_FUNCT3)
         3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
         3'b100, 3'b101:         f3_legal = !req.REQ_WE;
         default:                f3_legal = 1'b0;
      endcase
      // Offset-1 halves are rejected even though the memory could serve them
      case (req.REQ_FUNCT3[1:0])
         2'b01:   aligned = !req.REQ_ADDR[0];
         2'b10:   aligned = (req.REQ_ADDR[1:0] == 2'b00);
         default: aligned = 1'b1;
      endcase
      req_ok = f3_legal && aligned;
   end

   // State register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state sequencing of the memory protocol
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (!req_ok)         state_d = S_RESP;
               else if (req.REQ_WE) state_d = S_WR;
               else                 state_d = S_RD;
            end
         end
         S_RD:    state_d = S_RDW;
         S_RDW:   state_d = S_RESP;
         S_WR:    state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath next values: latch request on acceptance, capture read data in RDW
   always_comb begin
      addr_d  = addr_q;
      din_d   = din_q;
      size_d  = size_q;
      sign_d  = sign_q;
      err_d   = err_q;
      io_d    = io_q;
      rdata_d = rdata_q;
      if (accept) begin
         addr_d = req.REQ_ADDR;
         din_d  = req.REQ_WDATA;
         size_d = req.REQ_FUNCT3[1:0];
         sign_d = req.REQ_FUNCT3[2];
         err_d  = !req_ok;
         io_d   = (req.REQ_ADDR >= MMIO_BASE);
         if (!req_ok) rdata_d = 32'h0;
      end
      // Memory sizes its output from the held address/size, so capture it here
      if (state_q == S_RDW) rdata_d = mem.MEM_DOUT2;
      if (state_q == S_WR)  rdata_d = 32'h0;
   end

   // Datapath registers
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         addr_q  <= 32'h0;
         din_q   <= 32'h0;
         size_q  <= 2'b00;
         sign_q  <= 1'b0;
         err_q   <= 1'b0;
         io_q    <= 1'b0;
         rdata_q <= 32'h0;
      end else begin
         addr_q  <= addr_d;
         din_q   <= din_d;
         size_q  <= size_d;
         sign_q  <= sign_d;
         err_q   <= err_d;
         io_q    <= io_d;
         rdata_q <= rdata_d;
      end
   end

   // Outputs: strobes decoded from state only, everything else from registers
   always_comb begin
      req.REQ_READY     = (state_q == S_IDLE);
      req.RSP_VALID     = (state_q == S_RESP);
      req.RSP_RDATA     = rdata_q;
      req.RSP_ERR       = err_q && (state_q == S_RESP);
      req.RSP_IO        = io_q && (state_q == S_RESP);
      mem.LSU_MEM_RDEN2 = (state_q == S_RD);
      mem.LSU_MEM_WE2   = (state_q == S_WR);
      mem.LSU_MEM_ADDR2 = addr_q;
      mem.LSU_MEM_DIN2  = din_q;
      mem.LSU_MEM_SIZE  = size_q;
      mem.LSU_MEM_SIGN  = sign_q;
   end

endmodule

// File: tb/tb_otter_lsu.sv
// Directed bench for otter_lsu with a small OTTER-style memory model on port 2.
// Expected responses are queued at drive time and popped on RSP_VALID.
// Checks latency, strobes, held bus values, errors, IO flag and reset behaviour.
module tb_otter_lsu;

   localparam logic [31:0] IO_BASE = 32'h11000000;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   otter_lsu_if lsu_bus ();
   otter_mem_if mem_bus ();

   otter_lsu #(.MMIO_BASE(32'h00010000)) dut (
      .CLK (CLK),
      .RST (RST),
      .req (lsu_bus.slave),
      .mem (mem_bus.master)
   );

   // Memory model: registered word read on RDEN2, sized combinationally from live address
   logic [31:0] mem [0:1023];
   logic [31:0] rd_word = 32'h0;
   logic [31:0] io_in   = 32'h12345678;
   int          io_wr_cnt = 0;
   bit          preload = 1'b1;
   logic [31:0] sh;

   always @(posedge CLK) begin
      if (preload) begin
         mem[64]  <= 32'h80FF1234;
         mem[128] <= 32'h0;
      end else begin
         if (mem_bus.LSU_MEM_RDEN2)
            rd_word <= (mem_bus.LSU_MEM_ADDR2 >= IO_BASE) ? io_in : mem[mem_bus.LSU_MEM_ADDR2[11:2]];
         if (mem_bus.LSU_MEM_WE2) begin
            if (mem_bus.LSU_MEM_ADDR2 >= IO_BASE) io_wr_cnt <= io_wr_cnt + 1;
            else case (mem_bus.LSU_MEM_SIZE)
               2'd0: mem[mem_bus.LSU_MEM_ADDR2[11:2]][{mem_bus.LSU_MEM_ADDR2[1:0], 3'b000} +: 8]
                        <= mem_bus.LSU_MEM_DIN2[7:0];
               2'd1: mem[mem_bus.LSU_MEM_ADDR2[11:2]][{mem_bus.LSU_MEM_ADDR2[1:0], 3'b000} +: 16]
                        <= mem_bus.LSU_MEM_DIN2[15:0];
               default: mem[mem_bus.LSU_MEM_ADDR2[11:2]] <= mem_bus.LSU_MEM_DIN2;
            endcase
         end
      end
   end

   always_comb begin
      sh = rd_word >> {mem_bus.LSU_MEM_ADDR2[1:0], 3'b000};
      case (mem_bus.LSU_MEM_SIZE)
         2'd0: mem_bus.MEM_DOUT2 = mem_bus.LSU_MEM_SIGN ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
         2'd1: mem_bus.MEM_DOUT2 = mem_bus.LSU_MEM_SIGN ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
         default: mem_bus.MEM_DOUT2 = sh;
      endcase
   end

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic        io;
      int          lat;
      int          rd_cnt;
      int          wr_cnt;
   } exp_t;
   exp_t sb_q[$];

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ready"}, lsu_bus.REQ_READY, 1);
      chk({tag, "_rsp_valid"}, lsu_bus.RSP_VALID, 0);
      chk({tag, "_rsp_err"}, lsu_bus.RSP_ERR, 0);
      chk({tag, "_rsp_io"}, lsu_bus.RSP_IO, 0);
      chk({tag, "_rsp_rdata"}, lsu_bus.RSP_RDATA, 0);
      chk({tag, "_rden"}, mem_bus.LSU_MEM_RDEN2, 0);
      chk({tag, "_we"}, mem_bus.LSU_MEM_WE2, 0);
      chk({tag, "_addr"}, mem_bus.LSU_MEM_ADDR2, 0);
      chk({tag, "_din"}, mem_bus.LSU_MEM_DIN2, 0);
      chk({tag, "_size"}, {30'h0, mem_bus.LSU_MEM_SIZE}, 0);
      chk({tag, "_sign"}, mem_bus.LSU_MEM_SIGN, 0);
   endtask

   task automatic wait_ready();
      int k = 0;
      while (!lsu_bus.REQ_READY && k < 10) begin
         @(posedge CLK); #1;
         k++;
      end
      chk("ready_wait", lsu_bus.REQ_READY, 1);
   endtask

   // Drive a request and queue what the response must look like
   task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, input logic exp_io);
      exp_t e;
      e.rdata  = exp_rdata;
      e.err    = exp_err;
      e.io     = exp_io;
      e.lat    = exp_err ? 1 : (we ? 2 : 3);
      e.rd_cnt = (!exp_err && !we) ? 1 : 0;
      e.wr_cnt = (!exp_err && we) ? 1 : 0;
      sb_q.push_back(e);
      lsu_bus.REQ_WE     = we;
      lsu_bus.REQ_FUNCT3 = f3;
      lsu_bus.REQ_ADDR   = addr;
      lsu_bus.REQ_WDATA  = wdata;
      lsu_bus.REQ_VALID  = 1'b1;
   endtask

   // Follow the accepted request cycle by cycle until its response
   task automatic collect(input logic [31:0] addr, input logic [2:0] f3);
      int n = 0;
      int rd = 0;
      int wr = 0;
      bit done = 1'b0;
      exp_t e;
      while (!done && n < 10) begin
         @(posedge CLK); #1;
         n++;
         if (n == 1) begin
            lsu_bus.REQ_VALID = 1'b0;
            chk("size_latch", {30'h0, mem_bus.LSU_MEM_SIZE}, {30'h0, f3[1:0]});
            chk("sign_latch", mem_bus.LSU_MEM_SIGN, f3[2]);
         end
         if (mem_bus.LSU_MEM_RDEN2) rd++;
         if (mem_bus.LSU_MEM_WE2)   wr++;
         chk("strobe_excl", mem_bus.LSU_MEM_RDEN2 & mem_bus.LSU_MEM_WE2, 0);
         chk("addr_hold", mem_bus.LSU_MEM_ADDR2, addr);
         if (lsu_bus.RSP_VALID) begin
            done = 1'b1;
            chk("sb_nonempty", (sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
               e = sb_q.pop_front();
               chk("rsp_latency", n, e.lat);
               chk("rsp_rdata", lsu_bus.RSP_RDATA, e.rdata);
               chk("rsp_err", lsu_bus.RSP_ERR, e.err);
               chk("rsp_io", lsu_bus.RSP_IO, e.io);
               chk("rden_pulses", rd, e.rd_cnt);
               chk("we_pulses", wr, e.wr_cnt);
            end
         end
      end
      chk("rsp_seen", done, 1);
      @(posedge CLK); #1;
      chk("rsp_one_cycle", lsu_bus.RSP_VALID, 0);
      chk("ready_after", lsu_bus.REQ_READY, 1);
   endtask

   task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata,
                       input logic exp_err, input logic exp_io);
      wait_ready();
      drive(we, f3, addr, wdata, exp_rdata, exp_err, exp_io);
      collect(addr, f3);
      if (we) chk("din_hold", mem_bus.LSU_MEM_DIN2, wdata);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   // Directed sequence
   initial begin
      lsu_bus.REQ_VALID  = 1'b0;
      lsu_bus.REQ_WE     = 1'b0;
      lsu_bus.REQ_FUNCT3 = 3'b000;
      lsu_bus.REQ_ADDR   = 32'h0;
      lsu_bus.REQ_WDATA  = 32'h0;
      repeat (2) @(posedge CLK);
      #1;
      preload = 1'b0;
      chk_reset_vals("reset");
      @(negedge CLK);
      RST = 1'b0;

      // Sized loads from word 0x100 = 0x80FF1234
      send(0, 3'b000, 32'h103, 0, 32'hFFFFFF80, 0, 0);
      send(0, 3'b100, 32'h103, 0, 32'h00000080, 0, 0);
      send(0, 3'b001, 32'h102, 0, 32'hFFFF80FF, 0, 0);
      send(0, 3'b101, 32'h100, 0, 32'h00001234, 0, 0);
      send(0, 3'b010, 32'h100, 0, 32'h80FF1234, 0, 0);

      // Byte store then word readback
      send(1, 3'b000, 32'h101, 32'h000000AB, 32'h0, 0, 0);
      send(0, 3'b010, 32'h100, 0, 32'h80FFAB34, 0, 0);

      // Misaligned and illegal requests leave memory alone
      send(1, 3'b010, 32'h102, 32'h55555555, 32'h0, 1, 0);
      send(0, 3'b001, 32'h101, 0, 32'h0, 1, 0);
      send(0, 3'b011, 32'h100, 0, 32'h0, 1, 0);
      send(1, 3'b100, 32'h100, 32'h000000EE, 32'h0, 1, 0);
      chk("mem_unchanged", mem[64], 32'h80FFAB34);

      // IO region
      send(0, 3'b010, IO_BASE, 0, 32'h12345678, 0, 1);
      send(1, 3'b010, IO_BASE, 32'hCAFEF00D, 32'h0, 0, 1);
      chk("io_wr_pulses", io_wr_cnt, 1);

      // Reset while in WR: no write reaches memory
      wait_ready();
      lsu_bus.REQ_WE = 1'b1; lsu_bus.REQ_FUNCT3 = 3'b010;
      lsu_bus.REQ_ADDR = 32'h200; lsu_bus.REQ_WDATA = 32'hDEADBEEF;
      lsu_bus.REQ_VALID = 1'b1;
      @(posedge CLK); #1;
      lsu_bus.REQ_VALID = 1'b0;
      chk("wr_state_we", mem_bus.LSU_MEM_WE2, 1);
      RST = 1'b1;
      #1;
      chk_reset_vals("rst_in_wr");
      repeat (2) begin
         @(posedge CLK); #1;
         chk("no_rsp_in_wr_reset", lsu_bus.RSP_VALID, 0);
      end
      chk("wr_dropped", mem[128], 32'h0);
      @(negedge CLK);
      RST = 1'b0;
      send(0, 3'b010, 32'h200, 0, 32'h0, 0, 0);

      // Reset while in RDW, then release with the next request already valid
      wait_ready();
      lsu_bus.REQ_WE = 1'b0; lsu_bus.REQ_FUNCT3 = 3'b010;
      lsu_bus.REQ_ADDR = 32'h100; lsu_bus.REQ_VALID = 1'b1;
      @(posedge CLK); #1;
      lsu_bus.REQ_VALID = 1'b0;
      @(posedge CLK); #1;
      chk("rdw_rden_low", mem_bus.LSU_MEM_RDEN2, 0);
      RST = 1'b1;
      #1;
      chk_reset_vals("rst_in_rdw");
      drive(0, 3'b101, 32'h100, 0, 32'h0000AB34, 0, 0);
      repeat (2) begin
         @(posedge CLK); #1;
         chk("no_rsp_in_rdw_reset", lsu_bus.RSP_VALID, 0);
      end
      @(negedge CLK);
      RST = 1'b0;
      collect(32'h100, 3'b101);

      chk("sb_drained", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
